seq_divider_32: RTL and testbench

Multi-cycle unsigned 32-bit restoring divider, the inverse operation of the team's fast multipliers. It retires one quotient bit per clock. The trial subtraction each cycle reuses a `kogge_stone_32` instance, so the divider shares the verified adder datapath. It sits beside the multiplier blocks and serves any consumer that needs quotient/remainder through a start/done handshake.

---
 rtl/seq_divider_32.sv | 176 +++++++++++++++++
 tb/tb_seq_divider_32.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32.sv
// Unsigned 32-bit restoring divider, one quotient bit per clock, with the trial
// subtraction done by a Kogge-Stone adder (in1 + ~divisor + 1).

module kogge_stone_32 (
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g0;
    logic [31:0] p0;
    logic [31:0] g_pre;
    logic [31:0] p_pre;
    logic [32:0] carry;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi = gi + 1) begin : gen_gp
            assign g0[gi] = in1[gi] & in2[gi];
            assign p0[gi] = in1[gi] ^ in2[gi];
        end
    endgenerate

    // Five prefix levels; afterwards g_pre[i]/p_pre[i] cover bits i..0.
    always_comb begin
        logic [31:0] g_cur;
        logic [31:0] p_cur;
        logic [31:0] low_mask;
        g_cur = g0;
        p_cur = p0;
        for (int lvl = 0; lvl < 5; lvl++) begin
            low_mask = ~(32'hFFFF_FFFF << (1 << lvl));
            g_cur    = g_cur | (p_cur & (g_cur << (1 << lvl)));
            p_cur    = p_cur & ((p_cur << (1 << lvl)) | low_mask);
        end
        g_pre = g_cur;
        p_pre = p_cur;
    end

    assign carry[0]    = cin;
    assign carry[32:1] = g_pre | (p_pre & {32{cin}});
    assign sum         = p0 ^ carry[31:0];
    assign cout        = carry[32];
endmodule

module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        q_reg, q_next;
    logic [31:0]        r_reg, r_next;
    logic [31:0]        d_reg, d_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        quotient_reg, quotient_next;
    logic [31:0]        remainder_reg, remainder_next;
    logic               dbz_reg, dbz_next;

    logic [32:0]        shifted;
    logic [31:0]        diff;
    logic               diff_cout;
    logic               do_sub;
    logic [31:0]        r_step;
    logic [31:0]        q_step;

    assign shifted = {r_reg, q_reg[31]};

    kogge_stone_32 u_sub (
        .in1  (shifted[31:0]),
        .in2  (~d_reg),
        .cin  (1'b1),
        .sum  (diff),
        .cout (diff_cout)
    );

    // shifted[32] set means the partial remainder already exceeds any 32-bit divisor.
    assign do_sub = shifted[32] | diff_cout;
    assign r_step = do_sub ? diff : shifted[31:0];
    assign q_step = {q_reg[30:0], do_sub};

    always_comb begin
        state_next     = state_reg;
        q_next         = q_reg;
        r_next         = r_reg;
        d_next         = d_reg;
        cnt_next       = cnt_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (divisor != 32'd0) begin
                        q_next     = dividend;
                        d_next     = divisor;
                        r_next     = 32'd0;
                        cnt_next   = CNT_W'(WIDTH - 1);
                        state_next = CALC;
                    end else begin
                        quotient_next  = 32'hFFFF_FFFF;
                        remainder_next = dividend;
                        dbz_next       = 1'b1;
                        state_next     = DONE;
                    end
                end
            end
            CALC: begin
                r_next = r_step;
                q_next = q_step;
                if (cnt_reg == '0) begin
                    quotient_next  = q_step;
                    remainder_next = r_step;
                    dbz_next       = 1'b0;
                    state_next     = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            q_reg         <= '0;
            r_reg         <= '0;
            d_reg         <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            q_reg         <= q_next;
            r_reg         <= r_next;
            d_reg         <= d_next;
            cnt_reg       <= cnt_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

    assign ready       = (state_reg == IDLE);
    assign busy        = (state_reg == CALC);
    assign done        = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_divider_32.sv
// Directed and random checks for seq_divider_32; outputs sampled on the falling edge.

module tb_seq_divider_32;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider_32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation; returns results captured at done, edges from accept to done,
    // and number of sampled cycles with busy high.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eq, input logic [31:0] er, input logic edz);
        logic [31:0] q, r;
        logic        dz;
        int          lat, bc;
        do_op(a, b, q, r, dz, lat, bc);
        chk({tag, "_q"}, {32'd0, q}, {32'd0, eq});
        chk({tag, "_r"}, {32'd0, r}, {32'd0, er});
        chk({tag, "_dbz"}, {63'd0, dz}, {63'd0, edz});
        chk({tag, "_lat"}, 64'(lat), edz ? 64'd0 : 64'd32);
        chk({tag, "_busy_cycles"}, 64'(bc), edz ? 64'd0 : 64'd32);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        chk({tag, "_ready_back"}, {63'd0, ready}, 64'd1);
        $display("op %s: %0h / %0h -> q=%0h r=%0h dbz=%0b lat=%0d", tag, a, b, q, r, dz, lat);
    endtask

    initial begin
        logic [31:0] q, r, a, b;
        logic        dz;
        int          lat, bc, cyc, done_seen;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_quotient", {32'd0, quotient}, 64'd0);
        chk("rst_remainder", {32'd0, remainder}, 64'd0);
        chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        rst_n = 1'b1;

        directed("basic", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        directed("dbz", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        directed("max_by_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        directed("msb_by_max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        directed("max_by_msb", 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0);

        // start during CALC and during DONE must be ignored
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd10;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("ignore_done_seen", {63'd0, done}, 64'd1);
        chk("ignore_q", {32'd0, quotient}, 64'd100);
        chk("ignore_r", {32'd0, remainder}, 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignore_done_ready", {63'd0, ready}, 64'd1);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("ignore_no_second_op", 64'(done_seen), 64'd0);
        chk("ignore_q_held", {32'd0, quotient}, 64'd100);
        $display("op ignore: 1000 / 10 -> q=%0d r=%0d extra_activity=%0d", quotient, remainder, done_seen);

        // asynchronous reset in the middle of a calculation
        @(negedge clk);
        dividend = 32'd50000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrst_busy_before", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, ready}, 64'd1);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_quotient", {32'd0, quotient}, 64'd0);
        chk("midrst_remainder", {32'd0, remainder}, 64'd0);
        $display("op midrst: ready=%0b busy=%0b q=%0h r=%0h", ready, busy, quotient, remainder);
        @(negedge clk);
        rst_n = 1'b1;
        directed("after_rst", 32'd50, 32'd8, 32'd6, 32'd2, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            do_op(a, b, q, r, dz, lat, bc);
            chk("rand_identity", 64'(q) * 64'(b) + 64'(r), 64'(a));
            chk("rand_rem_lt_div", {63'd0, (r < b)}, 64'd1);
            chk("rand_lat", 64'(lat), 64'd32);
            $display("op rand %0d: %0h / %0h -> q=%0h r=%0h lat=%0d", i, a, b, q, r, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
